seven_segment_panel: RTL and testbench

Parametrised successor to the four-digit seven-segment top: drives an N-digit multiplexed display from a hex data bus, with button-driven cursor navigation and per-digit decimal-point toggling. Adds a select-mode state machine with inactivity timeout, wrap-around for any digit count, and blinking of the selected digit. Sits between the board's debounced button/switch inputs and the segment/digit pins.

---
 rtl/seven_segment_pkg.sv | 42 ++++
 rtl/seven_segment_decoder.sv | 13 +
 rtl/seven_segment_panel.sv | 132 +++++++++++++
 tb/tb_seven_segment_panel.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared segment indices, panel state encoding and hex glyph table
package seven_segment_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    SELECT = 1'b1
  } panel_state_e;

  // Active-low glyphs, bit SEG_A in bit 0 through SEG_G in bit 6.
  function automatic logic [6:0] hex_to_segments(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - combinational hex nibble to active-low a..g segments
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] segments_no
);

  always_comb begin
    segments_no = hex_to_segments(nibble_i);
  end

endmodule

// File: rtl/seven_segment_panel.sv
// rtl/seven_segment_panel.sv - N-digit multiplexed hex display with cursor select, dp toggle and blink
module seven_segment_panel
  import seven_segment_pkg::*;
#(
  parameter int DIGITS            = 8,
  parameter int CLOCK_DIVISIONS   = 18,
  parameter int BLINK_DIVISIONS   = 24,
  parameter int TIMEOUT_DIVISIONS = 28,
  localparam int CW               = $clog2(DIGITS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic                  button_left_i,
  input  logic                  button_center_i,
  input  logic                  button_right_i,
  output logic [7:0]            segment_enable_no,
  output logic [DIGITS-1:0]     digit_enable_no,
  output logic [DIGITS-1:0]     point_enable_o,
  output logic [CW-1:0]         cursor_o,
  output logic                  selecting_o
);

  localparam logic [CW-1:0]                LAST_DIGIT     = CW'(DIGITS - 1);
  localparam logic [CW-1:0]                CURSOR_ONE     = CW'(1);
  localparam logic [TIMEOUT_DIVISIONS-1:0] TIMEOUT_ONE    = TIMEOUT_DIVISIONS'(1);
  localparam logic [TIMEOUT_DIVISIONS-1:0] TIMEOUT_EXPIRE = ~TIMEOUT_ONE;

  logic [2:0]                   button_prev_q;
  logic [2:0]                   button_edge_q;
  logic                         edge_left, edge_center, edge_right;
  panel_state_e                 state_q;
  logic [CW-1:0]                cursor_q;
  logic [DIGITS-1:0]            points_q;
  logic [TIMEOUT_DIVISIONS-1:0] timeout_q;
  logic [CLOCK_DIVISIONS-1:0]   scan_count_q;
  logic [CW-1:0]                scan_index_q;
  logic [BLINK_DIVISIONS-1:0]   blink_count_q;
  logic [7:0]                   segment_q, segment_d;
  logic [DIGITS-1:0]            digit_q, digit_d;
  logic [3:0]                   nibble;
  logic [6:0]                   glyph_n;
  logic                         blank;

  // Button order in the vectors is {left, center, right}.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      button_prev_q <= 3'b000;
      button_edge_q <= 3'b000;
    end else begin
      button_prev_q <= {button_left_i, button_center_i, button_right_i};
      button_edge_q <= {button_left_i, button_center_i, button_right_i} & ~button_prev_q;
    end
  end

  assign {edge_left, edge_center, edge_right} = button_edge_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cursor_q  <= '0;
      points_q  <= '0;
      timeout_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_left || edge_right) state_q <= SELECT;
          // Entry into SELECT is always caused by an edge, so this also clears on entry.
          if (|button_edge_q) timeout_q <= '0;
        end
        SELECT: begin
          // Toggle uses the pre-move cursor; left wins over right.
          if (edge_center) points_q <= points_q ^ (DIGITS'(1) << cursor_q);
          if (edge_left) begin
            cursor_q <= (cursor_q == LAST_DIGIT) ? '0 : cursor_q + CURSOR_ONE;
          end else if (edge_right) begin
            cursor_q <= (cursor_q == '0) ? LAST_DIGIT : cursor_q - CURSOR_ONE;
          end
          if (|button_edge_q) begin
            timeout_q <= '0;
          end else begin
            timeout_q <= timeout_q + TIMEOUT_ONE;
            if (timeout_q == TIMEOUT_EXPIRE) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nibble = data_i[4*int'(scan_index_q) +: 4];

  seven_segment_decoder u_decoder (
    .nibble_i    (nibble),
    .segments_no (glyph_n)
  );

  always_comb begin
    blank = (state_q == SELECT) && blink_count_q[BLINK_DIVISIONS-1] && (scan_index_q == cursor_q);
    digit_d = ~(DIGITS'(1) << scan_index_q);
    segment_d = 8'hFF;
    if (!blank) begin
      segment_d[SEG_G:SEG_A] = glyph_n;
      segment_d[SEG_DP]      = ~points_q[scan_index_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_count_q  <= '0;
      scan_index_q  <= '0;
      blink_count_q <= '0;
      segment_q     <= 8'hFF;
      digit_q       <= '1;
    end else begin
      scan_count_q  <= scan_count_q + CLOCK_DIVISIONS'(1);
      blink_count_q <= blink_count_q + BLINK_DIVISIONS'(1);
      if (&scan_count_q) begin
        scan_index_q <= (scan_index_q == LAST_DIGIT) ? '0 : scan_index_q + CURSOR_ONE;
      end
      segment_q <= segment_d;
      digit_q   <= digit_d;
    end
  end

  assign segment_enable_no = segment_q;
  assign digit_enable_no   = digit_q;
  assign point_enable_o    = points_q;
  assign cursor_o          = cursor_q;
  assign selecting_o       = (state_q == SELECT);

endmodule

// File: tb/tb_seven_segment_panel.sv
// tb/tb_seven_segment_panel.sv - randomized bench for seven_segment_panel against a behavioural model
module tb_seven_segment_panel;

  localparam int CD = 2;
  localparam int BD = 5;
  localparam int TD = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        bl, bc, br;
  logic        tie0 = 1'b0;
  logic [19:0] data5;
  logic [31:0] data8;

  logic [7:0]  seg5, seg8;
  logic [4:0]  dig5, pts5;
  logic [7:0]  dig8, pts8;
  logic [2:0]  cur5, cur8;
  logic        sel5, sel8;

  seven_segment_panel #(
    .DIGITS(5), .CLOCK_DIVISIONS(CD), .BLINK_DIVISIONS(BD), .TIMEOUT_DIVISIONS(TD)
  ) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data5),
    .button_left_i(bl), .button_center_i(bc), .button_right_i(br),
    .segment_enable_no(seg5), .digit_enable_no(dig5), .point_enable_o(pts5),
    .cursor_o(cur5), .selecting_o(sel5)
  );

  seven_segment_panel #(
    .DIGITS(8), .CLOCK_DIVISIONS(CD), .BLINK_DIVISIONS(BD), .TIMEOUT_DIVISIONS(TD)
  ) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data8),
    .button_left_i(tie0), .button_center_i(tie0), .button_right_i(tie0),
    .segment_enable_no(seg8), .digit_enable_no(dig8), .point_enable_o(pts8),
    .cursor_o(cur8), .selecting_o(sel8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] hex_ff [16];

  // Model: cycles since reset release, panel state, and button edges awaiting action.
  int n, m_sel, m_cur, m_pts, m_t, s_sel, s_cur, s_pts;
  logic [2:0] prev_l, pend;
  logic [7:0] last_exp5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int digits, input logic [63:0] data, input int cyc,
                                         input int sel, input int cur, input int pts);
    int idx, nib;
    idx = ((cyc - 1) >> CD) % digits;
    nib = int'((data >> (4 * idx)) & 64'hF);
    if (sel != 0 && (((cyc - 1) >> (BD - 1)) & 1) == 1 && idx == cur) return 8'hFF;
    return ((pts >> idx) & 1) == 1 ? (hex_ff[nib] & 8'h7F) : hex_ff[nib];
  endfunction

  function automatic logic [31:0] exp_dig(input int digits, input int cyc);
    int idx;
    idx = ((cyc - 1) >> CD) % digits;
    return ~(32'd1 << idx) & ((32'd1 << digits) - 1);
  endfunction

  function automatic void apply(input logic [2:0] p);
    if (m_sel != 0) begin
      if (p[1]) m_pts = m_pts ^ (1 << m_cur);
      if (p[2]) m_cur = (m_cur + 1) % 5;
      else if (p[0]) m_cur = (m_cur + 4) % 5;
      if (p != 3'b000) m_t = 0;
      else begin
        m_t++;
        if (m_t == (1 << TD) - 1) m_sel = 0;
      end
    end else if (p[2] || p[0]) begin
      m_sel = 1;
      m_t = 0;
    end
  endfunction

  function automatic void model_reset();
    n = 0; m_sel = 0; m_cur = 0; m_pts = 0; m_t = 0;
    prev_l = 3'b000; pend = 3'b000;
  endfunction

  task automatic cycle(input logic l, input logic c, input logic r);
    bl = l; bc = c; br = r;
    @(posedge clk); #1;
    n++;
    s_sel = m_sel; s_cur = m_cur; s_pts = m_pts;
    apply(pend);
    pend = {bl, bc, br} & ~prev_l;
    prev_l = {bl, bc, br};
    last_exp5 = exp_seg(5, 64'(data5), n, s_sel, s_cur, s_pts);
    check("selecting", 32'(sel5), 32'(m_sel));
    check("cursor", 32'(cur5), 32'(m_cur));
    check("points", 32'(pts5), 32'(m_pts));
    check("seg5", 32'(seg5), 32'(last_exp5));
    check("dig5", 32'(dig5), exp_dig(5, n));
    check("seg8", 32'(seg8), 32'(exp_seg(8, 64'(data8), n, 0, 0, 0)));
    check("dig8", 32'(dig8), exp_dig(8, n));
  endtask

  task automatic press(input logic l, input logic c, input logic r);
    cycle(l, c, r);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values();
    check("rst_seg5", 32'(seg5), 32'hFF);
    check("rst_dig5", 32'(dig5), 32'h1F);
    check("rst_pts5", 32'(pts5), 32'h0);
    check("rst_cur5", 32'(cur5), 32'h0);
    check("rst_sel5", 32'(sel5), 32'h0);
    check("rst_seg8", 32'(seg8), 32'hFF);
    check("rst_dig8", 32'(dig8), 32'hFF);
  endtask

  initial begin
    bit found;
    hex_ff = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    rst_n = 1'b0; bl = 1'b0; bc = 1'b0; br = 1'b0;
    data8 = 32'h0123ABCD; data5 = 20'h9F4E2;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Scan order and glyphs on the 8-digit panel.
    for (int k = 0; k < 32; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (k == 0) begin
        check("first_dig8", 32'(dig8), 32'hFE);
        check("first_seg8", 32'(seg8), 32'hA1);
      end
      if (k == 28) check("last_seg8", 32'(seg8), 32'hC0);
    end

    // Cursor wrap on the 5-digit panel.
    press(1'b1, 1'b0, 1'b0);
    check("enter_sel", 32'(sel5), 32'h1);
    check("enter_cur", 32'(cur5), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      press(1'b1, 1'b0, 1'b0);
      check("left_wrap", 32'(cur5), 32'(i % 5));
    end
    press(1'b0, 1'b0, 1'b1);
    check("right_wrap", 32'(cur5), 32'h4);

    // Decimal point toggle at cursor 2.
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("dp_on", 32'(pts5), 32'h04);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("dp_off", 32'(pts5), 32'h00);

    // All three together at cursor 3.
    press(1'b1, 1'b0, 1'b0);
    check("cur3", 32'(cur5), 32'h3);
    press(1'b1, 1'b1, 1'b1);
    check("all3_pts", 32'(pts5), 32'h08);
    check("all3_cur", 32'(cur5), 32'h4);

    // Inactivity timeout.
    for (int i = 0; i < 62; i++) cycle(1'b0, 1'b0, 1'b0);
    check("before_timeout", 32'(sel5), 32'h1);
    cycle(1'b0, 1'b0, 1'b0);
    check("timeout", 32'(sel5), 32'h0);
    check("timeout_cur", 32'(cur5), 32'h4);
    check("timeout_pts", 32'(pts5), 32'h08);
    press(1'b0, 1'b1, 1'b0);
    check("idle_center_pts", 32'(pts5), 32'h08);
    check("idle_center_sel", 32'(sel5), 32'h0);

    // Randomized phase with periodic quiet stretches.
    for (int i = 0; i < 1600; i++) begin
      if (i % 16 == 0) begin
        data8 = $urandom;
        data5 = 20'($urandom);
      end
      if ((i / 100) % 4 == 3) cycle(1'b0, 1'b0, 1'b0);
      else cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset while the selected digit is blanked.
    press(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      cycle(1'b0, (k % 20) == 10, 1'b0);
      if (last_exp5 == 8'hFF) found = 1'b1;
    end
    check("blank_found", 32'(found), 32'h1);
    check("blank_seg5", 32'(seg5), 32'hFF);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    check("restart_dig5", 32'(dig5), 32'h1E);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
